// File: rtl/sram_responder.sv
// Word-addressed on-chip RAM responding to the CPU memory bus with byte-enabled
// writes, configurable read latency and wait states, and window/illegal-request errors.
module sram_responder #(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          READ_LATENCY = 1,
  parameter int          WAIT_STATES  = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  input  logic        write_req,
  input  logic        read_req,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  output logic        error
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH) << 2;
  localparam logic [3:0]  RD_BUSY   = 4'(READ_LATENCY + WAIT_STATES - 1);
  localparam logic [3:0]  WR_BUSY   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pend_rd_q, pend_rd_d;
  logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic                    rd_oow_q, rd_oow_d;
  logic [31:0]             read_data_q, read_data_d;
  logic                    error_q, error_d;

  logic [31:0]             mem [DEPTH];

  logic [31:0]             offset;
  logic                    in_win;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    accept;
  logic                    is_write;
  logic                    is_read;
  logic                    mem_we;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign offset   = addr - BASE_ADDR;
  assign in_win   = offset < WIN_BYTES;
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign accept   = ready && (write_req || read_req);
  assign is_write = accept && write_req;
  assign is_read  = accept && read_req && !write_req;
  assign mem_we   = is_write && in_win;

  assign ready           = (state_q != S_BUSY);
  assign read_data_valid = (state_q == S_RESP);
  assign read_data       = read_data_q;
  assign error           = error_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_rd_d   = pend_rd_q;
    rd_idx_d    = rd_idx_q;
    rd_oow_d    = rd_oow_q;
    read_data_d = read_data_q;
    error_d     = accept && (!in_win || (write_req && read_req));
    case (state_q)
      S_BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          pend_rd_d = 1'b0;
          if (pend_rd_q) begin
            // No write can be accepted while busy, so the array is still current.
            state_d     = S_RESP;
            read_data_d = rd_oow_q ? 32'h0 : mem[rd_idx_q];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (is_write) begin
          if (WR_BUSY != 4'd0) begin
            state_d = S_BUSY;
            cnt_d   = WR_BUSY;
          end
        end else if (is_read) begin
          if (RD_BUSY != 4'd0) begin
            state_d   = S_BUSY;
            cnt_d     = RD_BUSY;
            pend_rd_d = 1'b1;
            rd_idx_d  = idx;
            rd_oow_d  = !in_win;
          end else begin
            state_d     = S_RESP;
            read_data_d = in_win ? mem[idx] : 32'h0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      pend_rd_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_oow_q    <= 1'b0;
      read_data_q <= 32'h0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      rd_idx_q    <= rd_idx_d;
      rd_oow_q    <= rd_oow_d;
      read_data_q <= read_data_d;
      error_q     <= error_d;
    end
  end

  // Array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) mem[idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: instance A (latency 1, no waits), B (latency 3, 2 waits),
// C (latency 2, 2 waits) for the mid-read reset case.
module tb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic        reset_a;
  logic        ready_a, rdv_a, err_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic [3:0]  be_a;
  logic        wreq_a, rreq_a;

  // Instances B and C share request inputs
  logic        reset_b, reset_c;
  logic        ready_b, rdv_b, err_b, ready_c, rdv_c, err_c;
  logic [31:0] addr_s, wd_s, rd_b, rd_c;
  logic [3:0]  be_s;
  logic        wreq_s, rreq_s;

  sram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000_0000), .READ_LATENCY(1), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(reset_a), .ready(ready_a), .addr(addr_a), .write_data(wd_a),
    .byte_enable(be_a), .write_req(wreq_a), .read_req(rreq_a), .read_data(rd_a),
    .read_data_valid(rdv_a), .error(err_a));

  sram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000_0000), .READ_LATENCY(3), .WAIT_STATES(2)) dut_b (
    .clk(clk), .reset(reset_b), .ready(ready_b), .addr(addr_s), .write_data(wd_s),
    .byte_enable(be_s), .write_req(wreq_s), .read_req(rreq_s), .read_data(rd_b),
    .read_data_valid(rdv_b), .error(err_b));

  sram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000_0000), .READ_LATENCY(2), .WAIT_STATES(2)) dut_c (
    .clk(clk), .reset(reset_c), .ready(ready_c), .addr(addr_s), .write_data(wd_s),
    .byte_enable(be_s), .write_req(wreq_s), .read_req(rreq_s), .read_data(rd_c),
    .read_data_valid(rdv_c), .error(err_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request on A for one edge; returns mid-cycle after acceptance.
  task automatic a_op(input logic w, input logic r, input logic [31:0] ad,
                      input logic [31:0] d, input logic [3:0] be);
    wreq_a = w; rreq_a = r; addr_a = ad; wd_a = d; be_a = be;
    @(negedge clk);
    wreq_a = 1'b0; rreq_a = 1'b0;
  endtask

  task automatic s_op(input logic w, input logic r, input logic [31:0] ad,
                      input logic [31:0] d, input logic [3:0] be);
    wreq_s = w; rreq_s = r; addr_s = ad; wd_s = d; be_s = be;
    @(negedge clk);
    wreq_s = 1'b0; rreq_s = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    addr_a = '0; wd_a = '0; be_a = '0; wreq_a = 1'b0; rreq_a = 1'b0;
    addr_s = '0; wd_s = '0; be_s = '0; wreq_s = 1'b0; rreq_s = 1'b0;
    repeat (3) @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_rdv",   32'(rdv_a),   32'd0);
    chk("rst_rdata", rd_a,         32'h0);
    chk("rst_err",   32'(err_a),   32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);

    // Basic write then read-after-write
    a_op(1'b1, 1'b0, 32'h1000_0000, 32'hDEAD_BEEF, 4'hf);
    chk("wr_ready", 32'(ready_a), 32'd1);
    chk("wr_rdv",   32'(rdv_a),   32'd0);
    chk("wr_err",   32'(err_a),   32'd0);
    a_op(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'h0);
    chk("rd_data",  rd_a,         32'hDEAD_BEEF);
    chk("rd_valid", 32'(rdv_a),   32'd1);
    chk("rd_ready", 32'(ready_a), 32'd1);
    chk("rd_err",   32'(err_a),   32'd0);

    // Byte lanes
    a_op(1'b1, 1'b0, 32'h1000_0004, 32'hAAAA_AAAA, 4'hf);
    a_op(1'b1, 1'b0, 32'h1000_0004, 32'h1122_3344, 4'b0101);
    a_op(1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'h0);
    chk("lanes_data",  rd_a,       32'hAA22_AA44);
    chk("lanes_valid", 32'(rdv_a), 32'd1);
    @(negedge clk);
    chk("hold_rdv",  32'(rdv_a), 32'd0);
    chk("hold_data", rd_a,       32'hAA22_AA44);

    // Out-of-window read (below base)
    a_op(1'b0, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
    chk("oow_rd_valid", 32'(rdv_a), 32'd1);
    chk("oow_rd_data",  rd_a,       32'h0);
    chk("oow_rd_err",   32'(err_a), 32'd1);
    @(negedge clk);
    chk("err_one_cycle", 32'(err_a), 32'd0);

    // Out-of-window write must not alias onto word 0
    a_op(1'b1, 1'b0, 32'h2000_0000, 32'h1234_5678, 4'hf);
    chk("oow_wr_err", 32'(err_a), 32'd1);
    a_op(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'h0);
    chk("oow_wr_keep", rd_a,       32'hDEAD_BEEF);
    chk("oow_wr_err2", 32'(err_a), 32'd0);

    // Both requests: write plus error, no read response
    a_op(1'b1, 1'b1, 32'h1000_0008, 32'h5566_7788, 4'hf);
    chk("both_err", 32'(err_a), 32'd1);
    chk("both_rdv", 32'(rdv_a), 32'd0);
    a_op(1'b0, 1'b1, 32'h1000_0008, 32'h0, 4'h0);
    chk("both_wrote", rd_a,       32'h5566_7788);
    chk("both_rdv2",  32'(rdv_a), 32'd1);

    // Window edges
    a_op(1'b1, 1'b0, 32'h1000_0FFC, 32'hCAFE_F00D, 4'hf);
    chk("top_wr_err", 32'(err_a), 32'd0);
    a_op(1'b0, 1'b1, 32'h1000_0FFC, 32'h0, 4'h0);
    chk("top_rd", rd_a, 32'hCAFE_F00D);
    a_op(1'b0, 1'b1, 32'h1000_1000, 32'h0, 4'h0);
    chk("past_top_data", rd_a,       32'h0);
    chk("past_top_err",  32'(err_a), 32'd1);
    a_op(1'b0, 1'b1, 32'h0FFF_FFFC, 32'h0, 4'h0);
    chk("below_base_err", 32'(err_a), 32'd1);

    // B/C: write with two wait states
    s_op(1'b1, 1'b0, 32'h1000_0010, 32'h0BAD_F00D, 4'hf);
    chk("b_wr_k1", 32'(ready_b), 32'd0);
    chk("c_wr_k1", 32'(ready_c), 32'd0);
    @(negedge clk);
    chk("b_wr_k2", 32'(ready_b), 32'd0);
    @(negedge clk);
    chk("b_wr_k3", 32'(ready_b), 32'd1);
    chk("c_wr_k3", 32'(ready_c), 32'd1);

    // B: L=5 read; C: reset during its L=4 read
    s_op(1'b0, 1'b1, 32'h1000_0010, 32'h0, 4'h0);
    chk("b_rd_k1_ready", 32'(ready_b), 32'd0);
    chk("b_rd_k1_rdv",   32'(rdv_b),   32'd0);
    @(negedge clk);
    chk("b_rd_k2_ready", 32'(ready_b), 32'd0);
    reset_c = 1'b1;
    @(negedge clk);
    chk("b_rd_k3_ready", 32'(ready_b), 32'd0);
    chk("c_rst_k3_rdv",  32'(rdv_c),   32'd0);
    @(negedge clk);
    chk("b_rd_k4_ready", 32'(ready_b), 32'd0);
    chk("b_rd_k4_rdv",   32'(rdv_b),   32'd0);
    chk("c_rst_k4_rdv",  32'(rdv_c),   32'd0);
    reset_c = 1'b0;
    @(negedge clk);
    chk("b_rd_k5_ready", 32'(ready_b), 32'd1);
    chk("b_rd_k5_rdv",   32'(rdv_b),   32'd1);
    chk("b_rd_k5_data",  rd_b,         32'h0BAD_F00D);
    chk("c_rst_k5_rdv",  32'(rdv_c),   32'd0);
    chk("c_rst_ready",   32'(ready_c), 32'd1);
    chk("c_rst_data",    rd_c,         32'h0);
    @(negedge clk);
    chk("b_rd_k6_rdv",  32'(rdv_b), 32'd0);
    chk("c_rst_k6_rdv", 32'(rdv_c), 32'd0);

    // C retains array contents across reset
    s_op(1'b0, 1'b1, 32'h1000_0010, 32'h0, 4'h0);
    chk("c_rd_k1_ready", 32'(ready_c), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("c_rd_k3_rdv", 32'(rdv_c), 32'd0);
    @(negedge clk);
    chk("c_rd_k4_rdv",  32'(rdv_c),   32'd1);
    chk("c_rd_k4_data", rd_c,         32'h0BAD_F00D);
    chk("c_rd_k4_rdy",  32'(ready_c), 32'd1);
    @(negedge clk);
    chk("b_rd2_k5_rdv", 32'(rdv_b), 32'd1);

    // B: out-of-window read keeps full latency, error at k+1
    s_op(1'b0, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
    chk("b_oow_err_k1",   32'(err_b),   32'd1);
    chk("b_oow_ready_k1", 32'(ready_b), 32'd0);
    @(negedge clk);
    chk("b_oow_err_k2", 32'(err_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b_oow_rdv_k4", 32'(rdv_b), 32'd0);
    @(negedge clk);
    chk("b_oow_rdv_k5",  32'(rdv_b), 32'd1);
    chk("b_oow_data_k5", rd_b,       32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Word-addressed on-chip RAM that acts as the responder on the CPU memory bus: it accepts read and write requests from the CPU's `addr`/`write_req`/`read_req` interface, applies byte-enabled writes, and returns read data with a configurable latency and wait-state count. It sits between the CPU bus port and a block-RAM array and serves the program/data window the CPU boots from (0x1000_0000). It also lets the team exercise the CPU's handshake against non-zero latencies.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words (4 KiB by default).
- `BASE_ADDR`, 32'h1000_0000: byte address of word 0. Must be aligned to 4·2^ADDR_WIDTH.
- `READ_LATENCY`, 1: cycles from read acceptance to data. Legal range 1..4.
- `WAIT_STATES`, 0: extra cycles `ready` is held low after every accepted request. Legal range 0..7.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ready` out 1: responder can accept a request this cycle. Whenever `read_data_valid` is high, `ready` is also high.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `write_data` in 32: store data.
- `byte_enable` in 4: bit i enables byte lane i (bits 8i+7:8i) on writes. Ignored on reads.
- `write_req` in 1: write request, held by the initiator until accepted.
- `read_req` in 1: read request, held by the initiator until accepted.
- `read_data` out 32: read result. Holds its last value between valid pulses.
- `read_data_valid` out 1: one-cycle pulse qualifying `read_data`.
- `error` out 1: one-cycle pulse when a request was out of window or illegal.

## Operation
- **Acceptance.** A request is accepted on a rising edge where `ready`=1 and (`write_req` or `read_req`)=1. Inputs are sampled only at that edge.
- **Window.** `addr` is in window if BASE_ADDR ≤ addr < BASE_ADDR + 4·2^ADDR_WIDTH. The word index is (addr − BASE_ADDR)[ADDR_WIDTH+1:2].
- **Write.** On the acceptance edge, each enabled byte lane of the indexed word is updated with `write_data`. Disabled lanes are unchanged.
- **Read.** Data is taken from the array as it stands after all writes accepted at earlier edges (read-after-write returns the new data).
- **Both requests high.** If `write_req` and `read_req` are both high at acceptance, the request is treated as a write and `error` pulses. No read response is produced.
- **Out-of-window write.** The write is discarded, the array is unchanged, and `error` pulses.
- **Out-of-window read.** The read completes normally with `read_data`=32'h0 and `read_data_valid`, and `error` pulses.
- **States.**
  - IDLE: `ready`=1.
  - BUSY: `ready`=0; a down-counter runs and a pending-read flag is held.
  - RESP: `ready`=1, `read_data_valid`=1 for one cycle.
- **Transitions.**
  - IDLE→BUSY on accepting a read when READ_LATENCY+WAIT_STATES > 1.
  - IDLE→RESP on accepting a read when the total is 1.
  - IDLE→BUSY on accepting a write when WAIT_STATES > 0; otherwise stay in IDLE.
  - BUSY→RESP when the pending read's count expires; BUSY→IDLE when a write's count expires.
  - RESP behaves as IDLE for acceptance, so a new request can be taken in the RESP cycle.
- Only one read is ever outstanding.
- Memory contents are not cleared by reset.

## Timing
- **Reset values.** `ready`=1, `read_data_valid`=0, `read_data`=32'h0, `error`=0, state IDLE, counter 0, pending read cleared.
- **Read.** Let L = READ_LATENCY + WAIT_STATES, with the read accepted at edge k.
  - Cycles k+1 … k+L−1: `ready`=0, `read_data_valid`=0.
  - Cycle k+L: `ready`=1, `read_data_valid`=1, `read_data` valid.
- **Write.** Accepted at edge k: `ready`=0 for cycles k+1 … k+WAIT_STATES, then 1. With WAIT_STATES=0, one write per cycle is sustained.
- **Error.** `error` pulses in cycle k+1 after the offending acceptance, independent of latency.
- **Reset mid-operation.** Any pending read is dropped with no `read_data_valid`. Writes already accepted before reset remain in the array.
- **Idle requests.** A request held while `ready`=0 is not accepted and has no side effects.

## Test plan
- **Reset.** Assert `reset`, then release → `ready`=1, `read_data_valid`=0, `read_data`=0, `error`=0.
- **Basic write/read (READ_LATENCY=1, WAIT_STATES=0).** Write 0xDEADBEEF to 0x1000_0000 with be=4'hf; read the same address on the next edge → cycle after acceptance shows `read_data`=0xDEADBEEF, `read_data_valid`=1, `ready`=1.
- **Byte lanes.** Write 0xAAAAAAAA (be=f) to 0x1000_0004, then 0x11223344 with be=4'b0101 → read returns 0xAA22AA44.
- **Latency (READ_LATENCY=3, WAIT_STATES=2).** Read accepted at edge k → `ready`=0 in cycles k+1..k+4; valid with `ready`=1 at k+5. A write → `ready`=0 for exactly 2 cycles.
- **Out of window and illegal requests.**
  - Read 0x0000_0000 → valid with data 0 and an `error` pulse.
  - Write 0x2000_0000 → `error` pulse; a subsequent read of 0x1000_0000 is unchanged.
  - Both requests high → treated as a write, `error` pulses, no valid.
- **Reset mid-read (L=4).** Accept a read, assert `reset` at k+2 → no `read_data_valid` ever; after release `ready`=1 and the array contents are retained.
